// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the in-order RV32 pipeline control slice.
// This package holds the FSM state enum, the NOP control word and the stage indices.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
    } ctrl_t;

    // Control bits loaded into EX when a bubble is injected
    localparam ctrl_t NOP_CTRL = 5'b00000;

    localparam int unsigned STAGE_IF  = 32'd0;
    localparam int unsigned STAGE_ID  = 32'd1;
    localparam int unsigned STAGE_EX  = 32'd2;
    localparam int unsigned STAGE_MEM = 32'd3;
    localparam int unsigned STAGE_WB  = 32'd4;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline controller (master) and the core datapath/caches (slave).
interface pipeline_ctrl_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_STAGES = 5
);
    logic                  ins_busy;
    logic                  data_busy;
    logic                  branch_taken;
    logic [XLEN-1:0]       branch_target;
    logic [4:0]            id_rs1;
    logic [4:0]            id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [4:0]            ex_rd;
    logic                  ex_is_load;
    logic                  ex_reg_write;
    logic                  irq;
    logic                  mret;
    logic [XLEN-1:0]       pc;
    logic                  ins_read_en;
    logic [NUM_STAGES-1:0] stage_valid;
    logic                  advance;
    logic                  hold_front;
    logic                  bubble_ex;
    logic [NUM_STAGES-1:0] flush_mask;
    logic [XLEN-1:0]       epc;
    logic                  irq_ack;

    modport master (
        input  ins_busy, data_busy, branch_taken, branch_target,
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, ex_is_load, ex_reg_write, irq, mret,
        output pc, ins_read_en, stage_valid, advance, hold_front,
        output bubble_ex, flush_mask, epc, irq_ack
    );

    modport slave (
        output ins_busy, data_busy, branch_taken, branch_target,
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, ex_is_load, ex_reg_write, irq, mret,
        input  pc, ins_read_en, stage_valid, advance, hold_front,
        input  bubble_ex, flush_mask, epc, irq_ack
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the instruction in ID and a load in EX.
// It is kept standalone so the forwarding units can reuse the same comparison.
module hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       id_valid,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    input  logic       ex_reg_write,
    input  logic       ex_valid,
    output logic       load_use
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    // x0 is never a real dependency, so rd==0 never stalls
    always_comb begin
        rs1_hit_s = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit_s = id_use_rs2 && (id_rs2 == ex_rd);
        load_use  = id_valid && ex_valid && ex_is_load && ex_reg_write &&
                    (ex_rd != 5'd0) && (rs1_hit_s || rs2_hit_s);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// PC register, per-stage valid bits and stall/bubble/flush generation for an N-stage in-order core,
// including the interrupt drain-and-redirect sequence.
module pipeline_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     NUM_STAGES   = 5,
    parameter int unsigned     BRANCH_STAGE = STAGE_EX,
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            CLK,
    input  logic            RESET,
    pipeline_ctrl_if.master bus
);

    localparam int unsigned           CW         = $clog2(NUM_STAGES);
    localparam logic [CW-1:0]         CNT_INIT   = CW'(NUM_STAGES - 1);
    localparam logic [CW-1:0]         CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [NUM_STAGES-1:0] FRONT_MASK = {NUM_STAGES{1'b1}} >> (NUM_STAGES - BRANCH_STAGE);
    localparam logic [NUM_STAGES-1:0] EX_BIT     = {{(NUM_STAGES-1){1'b0}}, 1'b1} << BRANCH_STAGE;
    localparam logic [XLEN-1:0]       PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};

    fsm_state_t            state_r;
    logic [CW-1:0]         cnt_r;
    logic [XLEN-1:0]       pc_r;
    logic [XLEN-1:0]       epc_r;
    logic [NUM_STAGES-1:0] sv_r;
    logic                  irq_ack_r;

    logic                  gstall_s;
    logic                  adv_s;
    logic                  fetch_s;
    logic                  lu_raw_s;
    logic                  redirect_s;
    logic                  hold_s;
    logic                  irq_take_s;
    logic                  valid_in_s;
    logic [XLEN-1:0]       target_s;
    logic [NUM_STAGES-1:0] flush_s;
    logic [NUM_STAGES-1:0] shifted_s;
    logic [NUM_STAGES-1:0] sv_next_s;
    logic [XLEN-1:0]       pc_next_s;

    hazard_detect u_hazard (
        .id_rs1       (bus.id_rs1),
        .id_rs2       (bus.id_rs2),
        .id_use_rs1   (bus.id_use_rs1),
        .id_use_rs2   (bus.id_use_rs2),
        .id_valid     (sv_r[BRANCH_STAGE-1]),
        .ex_rd        (bus.ex_rd),
        .ex_is_load   (bus.ex_is_load),
        .ex_reg_write (bus.ex_reg_write),
        .ex_valid     (sv_r[BRANCH_STAGE]),
        .load_use     (lu_raw_s)
    );

    // Per-cycle priority: reset, global stall, redirect, load-use, normal/irq entry
    always_comb begin
        gstall_s   = bus.ins_busy | bus.data_busy;
        adv_s      = !RESET && !gstall_s;
        fetch_s    = !RESET && (state_r != DRAIN);
        redirect_s = adv_s && sv_r[BRANCH_STAGE] && (bus.branch_taken || bus.mret);
        hold_s     = adv_s && lu_raw_s && !redirect_s;
        irq_take_s = adv_s && (state_r == IDLE) && bus.irq && !hold_s;
        // The word fetched this cycle is dropped on a redirect, on irq entry and while trapping
        valid_in_s = fetch_s && (state_r == IDLE) && !redirect_s && !irq_take_s;
        target_s   = bus.mret ? epc_r : bus.branch_target;
        if (redirect_s) begin
            flush_s = FRONT_MASK;
        end else begin
            flush_s = {NUM_STAGES{1'b0}};
        end
    end

    // Next valid vector and next fetch address
    always_comb begin
        shifted_s = {sv_r[NUM_STAGES-2:0] & ~flush_s[NUM_STAGES-2:0], valid_in_s};
        if (hold_s) begin
            sv_next_s = (sv_r & FRONT_MASK) | (shifted_s & ~(FRONT_MASK | EX_BIT));
        end else begin
            sv_next_s = shifted_s;
        end
        if (state_r == REDIRECT) begin
            pc_next_s = TRAP_VECTOR;
        end else if (redirect_s) begin
            pc_next_s = target_s;
        end else if ((state_r == IDLE) && !hold_s && !irq_take_s) begin
            pc_next_s = pc_r + PC_STEP;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // State registers and trap FSM; nothing moves while the caches stall
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            pc_r      <= RESET_PC;
            epc_r     <= {XLEN{1'b0}};
            sv_r      <= {NUM_STAGES{1'b0}};
            irq_ack_r <= 1'b0;
        end else if (adv_s) begin
            pc_r      <= pc_next_s;
            sv_r      <= sv_next_s;
            irq_ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (irq_take_s) begin
                        state_r <= DRAIN;
                        cnt_r   <= CNT_INIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DRAIN: begin
                    if (cnt_r <= CNT_ONE) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= REDIRECT;
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                    end
                end
                REDIRECT: begin
                    epc_r     <= pc_r;
                    irq_ack_r <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end else begin
            irq_ack_r <= 1'b0;
        end
    end

    assign bus.pc          = pc_r;
    assign bus.ins_read_en = fetch_s;
    assign bus.stage_valid = sv_r;
    assign bus.advance     = adv_s;
    assign bus.hold_front  = hold_s;
    assign bus.bubble_ex   = hold_s;
    assign bus.flush_mask  = flush_s;
    assign bus.epc         = epc_r;
    assign bus.irq_ack     = irq_ack_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: fill, load-use, branch override,
// cache stall, interrupt drain/redirect, mret and reset during drain.
module tb_pipeline_ctrl;

    logic CLK;
    logic RESET;
    int   n_cmp;
    int   n_err;

    pipeline_ctrl_if #(.XLEN(32), .NUM_STAGES(5)) bus ();

    pipeline_ctrl #(
        .XLEN(32), .NUM_STAGES(5), .BRANCH_STAGE(2),
        .RESET_PC(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_hazard();
        bus.ex_is_load   = 1'b0;
        bus.ex_reg_write = 1'b0;
        bus.ex_rd        = 5'd0;
        bus.id_rs1       = 5'd0;
        bus.id_rs2       = 5'd0;
        bus.id_use_rs1   = 1'b0;
        bus.id_use_rs2   = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 32'h0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RESET = 1'b1;
        bus.ins_busy = 1'b0;
        bus.data_busy = 1'b0;
        bus.irq = 1'b0;
        bus.mret = 1'b0;
        clear_hazard();

        // Reset state
        step();
        step();
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_valid", {27'd0, bus.stage_valid}, 32'h0);
        chk("rst_epc", bus.epc, 32'h0);
        chk("rst_irq_ack", {31'd0, bus.irq_ack}, 32'h0);
        chk("rst_read_en", {31'd0, bus.ins_read_en}, 32'h0);
        chk("rst_advance", {31'd0, bus.advance}, 32'h0);
        RESET = 1'b0;
        #1;
        chk("run_read_en", {31'd0, bus.ins_read_en}, 32'h1);
        chk("run_advance", {31'd0, bus.advance}, 32'h1);

        // Eight unstalled cycles
        chk("fill_pc0", bus.pc, 32'h00); chk("fill_v0", {27'd0, bus.stage_valid}, 32'h00); step();
        chk("fill_pc1", bus.pc, 32'h04); chk("fill_v1", {27'd0, bus.stage_valid}, 32'h01); step();
        chk("fill_pc2", bus.pc, 32'h08); chk("fill_v2", {27'd0, bus.stage_valid}, 32'h03); step();
        chk("fill_pc3", bus.pc, 32'h0C); chk("fill_v3", {27'd0, bus.stage_valid}, 32'h07); step();
        chk("fill_pc4", bus.pc, 32'h10); chk("fill_v4", {27'd0, bus.stage_valid}, 32'h0F); step();
        chk("fill_pc5", bus.pc, 32'h14); chk("fill_v5", {27'd0, bus.stage_valid}, 32'h1F); step();
        chk("fill_pc6", bus.pc, 32'h18); step();
        chk("fill_pc7", bus.pc, 32'h1C); step();
        chk("fill_pc8", bus.pc, 32'h20);

        // Interrupt at pc=0x20: entry, 4 drain cycles, redirect
        bus.irq = 1'b1;
        step();
        bus.irq = 1'b0;
        #1;
        chk("irq_entry_pc", bus.pc, 32'h20);
        chk("irq_entry_v", {27'd0, bus.stage_valid}, 32'h1E);
        chk("drain_rd_en0", {31'd0, bus.ins_read_en}, 32'h0); step();
        chk("drain_rd_en1", {31'd0, bus.ins_read_en}, 32'h0); step();
        chk("drain_rd_en2", {31'd0, bus.ins_read_en}, 32'h0); step();
        chk("drain_rd_en3", {31'd0, bus.ins_read_en}, 32'h0); step();
        chk("redir_rd_en", {31'd0, bus.ins_read_en}, 32'h1);
        chk("redir_ack_lo", {31'd0, bus.irq_ack}, 32'h0);
        chk("redir_pc", bus.pc, 32'h20);
        chk("redir_v", {27'd0, bus.stage_valid}, 32'h00);
        step();
        chk("trap_pc", bus.pc, 32'h100);
        chk("trap_epc", bus.epc, 32'h20);
        chk("trap_ack", {31'd0, bus.irq_ack}, 32'h1);
        step();
        chk("trap_ack_pulse", {31'd0, bus.irq_ack}, 32'h0);
        chk("trap_pc1", bus.pc, 32'h104);
        chk("trap_v1", {27'd0, bus.stage_valid}, 32'h01);
        step();
        step();
        chk("pre_mret_v", {27'd0, bus.stage_valid}, 32'h07);

        // mret returns to epc and flushes the front
        bus.mret = 1'b1;
        #1;
        chk("mret_flush", {27'd0, bus.flush_mask}, 32'h03);
        step();
        bus.mret = 1'b0;
        chk("mret_pc", bus.pc, 32'h20);
        chk("mret_v", {27'd0, bus.stage_valid}, 32'h08);

        // Reset in the middle of a drain
        bus.irq = 1'b1;
        step();
        bus.irq = 1'b0;
        step();
        chk("drain2_rd_en", {31'd0, bus.ins_read_en}, 32'h0);
        RESET = 1'b1;
        #1;
        chk("rst_drain_rd_en", {31'd0, bus.ins_read_en}, 32'h0);
        step();
        chk("rst_drain_pc", bus.pc, 32'h0);
        chk("rst_drain_epc", bus.epc, 32'h0);
        chk("rst_drain_v", {27'd0, bus.stage_valid}, 32'h0);
        RESET = 1'b0;
        #1;
        chk("rst_drain_idle", {31'd0, bus.ins_read_en}, 32'h1);

        // Load-use interlock
        step(); step(); step(); step();
        chk("lu_pre_pc", bus.pc, 32'h10);
        chk("lu_pre_v", {27'd0, bus.stage_valid}, 32'h0F);
        bus.ex_is_load = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd0;
        bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1;
        #1;
        chk("lu_x0_hold", {31'd0, bus.hold_front}, 32'h0);
        bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
        #1;
        chk("lu_hold", {31'd0, bus.hold_front}, 32'h1);
        chk("lu_bubble", {31'd0, bus.bubble_ex}, 32'h1);
        step();
        clear_hazard();
        #1;
        chk("lu_pc_held", bus.pc, 32'h10);
        chk("lu_v", {27'd0, bus.stage_valid}, 32'h1B);
        chk("lu_one_cycle", {31'd0, bus.hold_front}, 32'h0);
        step();
        chk("lu_resume_pc", bus.pc, 32'h14);
        chk("lu_resume_v", {27'd0, bus.stage_valid}, 32'h17);

        // Branch in the same cycle as a load-use hit
        bus.ex_is_load = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd7;
        bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b1;
        bus.branch_taken = 1'b1; bus.branch_target = 32'h80;
        #1;
        chk("br_hold", {31'd0, bus.hold_front}, 32'h0);
        chk("br_bubble", {31'd0, bus.bubble_ex}, 32'h0);
        chk("br_flush", {27'd0, bus.flush_mask}, 32'h03);
        step();
        clear_hazard();
        #1;
        chk("br_pc", bus.pc, 32'h80);
        chk("br_v", {27'd0, bus.stage_valid}, 32'h08);

        // Data cache busy for three cycles
        bus.data_busy = 1'b1;
        #1;
        chk("busy_advance", {31'd0, bus.advance}, 32'h0);
        chk("busy_rd_en", {31'd0, bus.ins_read_en}, 32'h1);
        step(); chk("busy_pc0", bus.pc, 32'h80); chk("busy_v0", {27'd0, bus.stage_valid}, 32'h08);
        step(); chk("busy_pc1", bus.pc, 32'h80); chk("busy_v1", {27'd0, bus.stage_valid}, 32'h08);
        step(); chk("busy_pc2", bus.pc, 32'h80); chk("busy_v2", {27'd0, bus.stage_valid}, 32'h08);
        bus.data_busy = 1'b0;
        step();
        chk("busy_resume_pc", bus.pc, 32'h84);
        chk("busy_resume_v", {27'd0, bus.stage_valid}, 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Parametrised pipeline control block for the in-order RV32 cores in the neuromorphic NoC tiles. It owns the PC register and the per-stage valid bits. It generates stall, bubble and flush controls for a generic N-stage pipeline: global cache stall, load-use interlock, branch flush and interrupt entry/return. It replaces the stall/flush/PC logic that is currently hand-coded inside each core, and the datapath pipeline registers consume its outputs.

Parameters:
XLEN, 32, datapath/PC width
NUM_STAGES, 5, pipeline depth; stage 0 = IF, stage NUM_STAGES-1 = WB; legal range 3..8
BRANCH_STAGE, 2, index of the stage that resolves branches (EX); legal range 1..NUM_STAGES-2
RESET_PC, 32'h0000_0000, first fetch address after reset
TRAP_VECTOR, 32'h0000_0100, interrupt handler entry address

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
ins_busy  in  1  instruction cache busy-wait
data_busy  in  1  data cache busy-wait
branch_taken  in  1  branch/jump resolved taken in BRANCH_STAGE
branch_target  in  XLEN  target for branch_taken
id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1 each  instruction in ID reads rs1/rs2
ex_rd  in  5  destination register of the instruction in EX
ex_is_load  in  1  instruction in EX is a load
ex_reg_write  in  1  instruction in EX writes rd
irq  in  1  level interrupt request
mret  in  1  trap return, resolved in BRANCH_STAGE
pc  out  XLEN  address being fetched this cycle
ins_read_en  out  1  instruction fetch request
stage_valid  out  NUM_STAGES  per-stage valid bits; bit 0 = IF
advance  out  1  pipeline registers load this cycle
hold_front  out  1  IF/ID registers hold (load-use stall)
bubble_ex  out  1  inject NOP control bits into EX register
flush_mask  out  NUM_STAGES  stages to squash on the next advance
epc  out  XLEN  saved return PC
irq_ack  out  1  one-cycle interrupt acknowledge pulse

Behaviour:
- Reset values: pc=RESET_PC, stage_valid=0, epc=0, irq_ack=0, FSM=IDLE, drain counter=0. While RESET=1 all combinational outputs are 0.
- gstall = ins_busy | data_busy. advance = !RESET & !gstall.
- ins_read_en = !RESET & (FSM != DRAIN). It is independent of busy signals, so there is no combinational loop with the caches.
- Priority per cycle: RESET > gstall > mret/branch redirect > load-use > normal.
- gstall: every register holds, including pc, valid, FSM and counter. bubble_ex=0 and flush_mask=0.
- Normal advance: pc <= pc+4 (mod 2^XLEN). stage_valid <= {stage_valid[N-2:0], ins_read_en}.
- Load-use condition: ex_is_load & ex_reg_write & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)), gated by stage_valid of both stages.
- Load-use response: hold_front=1, bubble_ex=1, pc held, stage_valid[BRANCH_STAGE] <= 0. Stages below BRANCH_STAGE hold their valid bits; older stages shift. The stall lasts exactly one cycle because the load leaves EX.
- branch_taken (valid in BRANCH_STAGE): pc <= branch_target. flush_mask[BRANCH_STAGE-1:0] = all ones, so those valid bits clear on the advance. Branch overrides load-use in the same cycle: hold_front=0, bubble_ex=0.
- mret: behaves as a branch with target = epc.
- FSM IDLE -> DRAIN when irq=1 on an advancing cycle. The instruction currently in IF is not enqueued (valid-in 0). The counter loads NUM_STAGES-1.
- DRAIN: fetch is off and bubbles enter. The counter decrements only on advancing cycles. Branches resolving in flight still update pc. At counter 0 -> REDIRECT.
- REDIRECT (1 cycle, advancing): epc <= pc, pc <= TRAP_VECTOR, irq_ack=1 -> IDLE. If gstall is high, REDIRECT holds and irq_ack stays low until the cycle it advances.
- irq deasserting during DRAIN does not abort the drain; the trap is taken.
- Reset mid-DRAIN or mid-REDIRECT returns to the reset state; epc is cleared.

Decomposition:
- Package cpu_pipe_pkg: the fsm_state_t enum {IDLE, DRAIN, REDIRECT}, the NOP control encoding, and stage index constants IF/ID/EX/MEM/WB.
- One sub-module: hazard_detect, the combinational load-use comparator, reused later by the forwarding units.

Test Plan:
- Reset, then 8 unstalled cycles -> pc sequence 0,4,...,0x1C. stage_valid fills 00001 -> 11111 by cycle 5.
- ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> hold_front=1 and bubble_ex=1 for one cycle. pc holds at 0x10. stage_valid[2]=0 the next cycle.
- branch_taken=1, branch_target=0x80 in the same cycle as a load-use hit -> pc=0x80 next cycle, bubble_ex=0, stage_valid[1:0]=00.
- data_busy held high for 3 cycles mid-stream -> pc, stage_valid and FSM unchanged for 3 cycles, then resume at the held pc+4.
- irq pulsed one cycle at pc=0x20 -> 4 drain cycles with ins_read_en=0. Then epc=0x20, pc=0x100 and irq_ack=1 for exactly one cycle. A later mret -> pc=0x20.
- RESET asserted during DRAIN -> next cycle pc=RESET_PC, FSM=IDLE, epc=0, stage_valid=0.
